// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a first-word fall-through byte FIFO.
// Ports:
//   i_clk, i_rst_n          system clock, synchronous active-low reset
//   i_ps2_clk, i_ps2_data   asynchronous PS/2 lines
//   o_data, o_valid         FIFO head byte and non-empty flag
//   i_ready                 consumer pops the head byte when o_valid is high
//   o_count                 bytes currently stored (0..FIFO_DEPTH)
//   o_frame_err             one-cycle pulse: bad stop/parity or inter-bit timeout
//   o_overflow              one-cycle pulse: received byte dropped, FIFO full
// Build option: define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_fifo #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_ps2_clk,
   input  logic                          i_ps2_data,
   output logic [7:0]                    o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_frame_err,
   output logic                          o_overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Line synchronisers; reset to the idle-high line level
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   fall;
   logic                   rx_bit;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign rx_bit = data_sync[SYNC_STAGES-1];

   // Frame receiver state
   state_t        state, state_next;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic [7:0]    shift, shift_next;
   logic [TW-1:0] tmo_cnt, tmo_next;
   logic          push_req, push_next;
   logic          err_next;
   logic          parity_ok;
`ifdef PS2_RX_PARITY_CHECK_EN
   logic          par_bit, par_next;
   // Data bits plus parity must carry an odd number of ones
   assign parity_ok = ^{shift, par_bit};
`else
   assign parity_ok = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         tmo_cnt     <= '0;
         push_req    <= 1'b0;
         o_frame_err <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
         par_bit     <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         shift       <= shift_next;
         tmo_cnt     <= tmo_next;
         push_req    <= push_next;
         o_frame_err <= err_next;
`ifdef PS2_RX_PARITY_CHECK_EN
         par_bit     <= par_next;
`endif
      end
   end

   // Next-state and datapath decode; advances only on a synchronised fall
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      tmo_next     = tmo_cnt;
      push_next    = 1'b0;
      err_next     = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_next     = par_bit;
`endif
      if (state != IDLE) begin
         tmo_next = fall ? '0 : TW'(tmo_cnt + TW'(1));
      end
      case (state)
         IDLE: begin
            tmo_next = '0;
            if (fall && !rx_bit) begin
               state_next   = DATA;
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_next   = {rx_bit, shift[7:1]};
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_next = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
`ifdef PS2_RX_PARITY_CHECK_EN
               par_next   = rx_bit;
`endif
               state_next = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_next = IDLE;
               if (rx_bit && parity_ok) push_next = 1'b1;
               else                     err_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // Stalled line inside a frame: abandon it
      if ((state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
         state_next = IDLE;
         tmo_next   = '0;
         push_next  = 1'b0;
         err_next   = 1'b1;
      end
   end

   // FWFT FIFO; the pushed byte is still held in the shift register
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
   logic [CW-1:0] count_next;
   logic [7:0]    head_next;
   logic          pop, full, wr_en;

   assign pop   = o_valid & i_ready;
   assign full  = (o_count == CW'(FIFO_DEPTH));
   assign wr_en = push_req & (~full | pop);

   always_comb begin
      rd_next    = pop   ? rd_ptr + AW'(1) : rd_ptr;
      wr_next    = wr_en ? wr_ptr + AW'(1) : wr_ptr;
      count_next = o_count;
      case ({wr_en, pop})
         2'b10:   count_next = o_count + CW'(1);
         2'b01:   count_next = o_count - CW'(1);
         default: count_next = o_count;
      endcase
      // New head is the incoming byte when it lands in the slot being exposed
      head_next = (wr_en && (rd_next == wr_ptr)) ? shift : mem[rd_next];
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_count    <= '0;
         o_valid    <= 1'b0;
         o_data     <= 8'h00;
         o_overflow <= 1'b0;
      end else begin
         wr_ptr     <= wr_next;
         rd_ptr     <= rd_next;
         o_count    <= count_next;
         o_valid    <= (count_next != '0);
         if (count_next != '0) o_data <= head_next;
         o_overflow <= push_req & full & ~pop;
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised self-checking bench for ps2_rx_fifo with a queue-based reference model.
module tb_ps2_rx_fifo;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned TMO   = 300;
   localparam int unsigned HP    = 10;   // PS/2 half period in i_clk cycles

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic       ready;
   logic [7:0] o_data;
   logic       o_valid;
   logic [3:0] o_count;
   logic       o_frame_err;
   logic       o_overflow;

   ps2_rx_fifo #(
      .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
      .o_data(o_data), .o_valid(o_valid), .i_ready(ready), .o_count(o_count),
      .o_frame_err(o_frame_err), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         err_seen = 0, ovf_seen = 0, err_exp = 0, ovf_exp = 0;
   int         rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
   logic [7:0] q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   function automatic bit frame_ok(input logic [7:0] d, input logic p, input logic s);
`ifdef PS2_RX_PARITY_CHECK_EN
      return s && ((^d ^ p) == 1'b1);
`else
      return s;
`endif
   endfunction

   // Drive ready, count pulses, and check every pop against the model
   always @(negedge clk) begin
      if (rdy_mode == 2) ready = 1'($urandom_range(0, 1));
      else               ready = (rdy_mode == 1);
      if (o_frame_err) err_seen++;
      if (o_overflow)  ovf_seen++;
      if (rst_n && o_valid && ready) begin
         if (q.size() == 0) chk("pop_unexpected", 1, 0);
         else               chk("pop_data", o_data, q.pop_front());
      end
   end

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b1;
   endtask

   // Full frame; the model takes the byte at the cycle the DUT is due to store it
   task automatic send(input logic [7:0] d, input logic p, input logic s, input bit lat);
      bit ok;
      bit was_empty;
      ok = frame_ok(d, p, s);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(p);
      ps2_data = s;
      repeat (HP) @(posedge clk);
      was_empty = (q.size() == 0) && !o_valid;
      #1 ps2_clk = 1'b0;
      repeat (SYNC + 1) @(posedge clk);
      #1;
      if (lat && ok && was_empty) chk("latency_low", o_valid, 0);
      @(posedge clk);
      #1;
      if (lat && ok && was_empty) chk("latency_high", o_valid, 1);
      if (ok) begin
         if (q.size() >= DEPTH) ovf_exp++;
         else                   q.push_back(d);
      end else begin
         err_exp++;
      end
      repeat (HP - SYNC - 2) @(posedge clk);
      #1 ps2_clk = 1'b1;
      ps2_data = 1'b1;
   endtask

   task automatic drain(input string tag);
      rdy_mode = 1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_model_empty"}, q.size(), 0);
      chk({tag, "_count"}, o_count, 0);
      chk({tag, "_valid"}, o_valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_count"}, o_count, 0);
      chk({tag, "_data"}, o_data, 8'h00);
      chk({tag, "_frame_err"}, o_frame_err, 0);
      chk({tag, "_overflow"}, o_overflow, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      logic [7:0] d;
      logic p, s;
      rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // Single frame consumed immediately, with push latency
      rdy_mode = 1;
      send(8'h1C, 1'b0, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("single_count", o_count, 0);
      chk("single_errs", err_seen, 0);

      // Two frames held, then drained in order
      rdy_mode = 0;
      send(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
      send(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("two_count", o_count, 2);
      chk("two_head", o_data, 8'hF0);
      drain("two");

      // Overflow on the ninth push
      rdy_mode = 0;
      for (int i = 1; i <= 9; i++) send(8'(i), odd_par(8'(i)), 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("full_count", o_count, DEPTH);
      chk("full_head", o_data, 8'h01);
      chk("overflow_pulses", ovf_seen, 1);
      drain("full");

      // Bad parity: rejected only when the check is built in
      rdy_mode = 0;
      send(8'h1C, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("badpar_count", o_count, q.size());
      chk("badpar_errs", err_seen, err_exp);
      drain("badpar");

      // Bad stop bit
      send(8'hA5, odd_par(8'hA5), 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("badstop_errs", err_seen, err_exp);
      chk("badstop_count", o_count, 0);

      // Timeout after four data bits, then a clean frame
      rdy_mode = 1;
      e0 = err_seen;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TMO + 100) @(posedge clk);
      #1;
      chk("timeout_pulses", err_seen - e0, 1);
      err_exp++;
      send(8'h5A, odd_par(8'h5A), 1'b1, 1'b1);
      drain("after_timeout");

      // Reset in the middle of a frame
      e0 = err_seen;
      d = 8'h29;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(d[i]);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("midreset_no_err", err_seen, e0);
      send(8'h29, odd_par(8'h29), 1'b1, 1'b1);
      drain("after_reset");

      // Random traffic with random consumer
      rdy_mode = 2;
      for (int n = 0; n < 30; n++) begin
         d = 8'($urandom);
         p = odd_par(d) ^ ($urandom_range(0, 4) == 0);
         s = ($urandom_range(0, 9) != 0);
         send(d, p, s, 1'b0);
      end
      drain("rand_ready");

      // Random traffic with consumer stalled, may overflow
      rdy_mode = 0;
      for (int n = 0; n < 12; n++) begin
         d = 8'($urandom);
         p = odd_par(d) ^ ($urandom_range(0, 5) == 0);
         send(d, p, 1'b1, 1'b0);
      end
      repeat (3) @(posedge clk);
      #1 chk("stall_count", o_count, q.size());
      drain("rand_stall");

      chk("total_frame_err", err_seen, err_exp);
      chk("total_overflow", ovf_seen, ovf_exp);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning byte FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops on i_ps2_clk and i_ps2_data (>=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning i_clk cycles allowed between PS/2 clock falls inside a frame.
REQ-004 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports i_ps2_clk and i_ps2_data  input  1 each  asynchronous PS/2 lines.
REQ-007 SHALL have port o_data  output  8  FIFO head byte.
REQ-008 SHALL have port o_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port i_ready  input  1  consumer accepts head byte.
REQ-010 SHALL have port o_count  output  $clog2(FIFO_DEPTH)+1  bytes currently stored.
REQ-011 SHALL have ports o_frame_err, o_overflow  output  1 each  single-cycle error pulses.

Function
REQ-012 SHALL synchronise both PS/2 lines through SYNC_STAGES flops; a fall is synced clock previous-high, current-low, valid for one i_clk cycle.
REQ-013 SHALL run FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on a detected fall.
REQ-014 IDLE: fall with data 0 (start) -> DATA, bit count 0; fall with data 1 -> stay IDLE, no error.
REQ-015 DATA: each fall shifts data in LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: fall captures parity bit -> STOP.
REQ-017 STOP: fall with data 1 and parity check passing -> push byte, IDLE; otherwise discard, pulse o_frame_err, IDLE.
REQ-018 Byte push SHALL occur in the cycle after the stop-bit fall is detected; o_valid rises exactly SYNC_STAGES+2 i_clk cycles after the stop-bit fall on i_ps2_clk (FIFO empty beforehand).
REQ-019 Timeout counter SHALL clear on every detected fall and count in non-IDLE states; reaching TIMEOUT_CYCLES -> discard partial frame, pulse o_frame_err, IDLE.
REQ-020 FIFO SHALL be first-word fall-through: o_data = oldest byte whenever o_valid is 1; o_data undefined-but-stable (held) when empty.
REQ-021 Pop SHALL occur when o_valid && i_ready; i_ready while empty is ignored.
REQ-022 Push when full without simultaneous pop SHALL drop the new byte, keep contents, pulse o_overflow.
REQ-023 Push and pop same cycle SHALL both take effect, o_count unchanged, including when full (no overflow).
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; o_count ranges 0..FIFO_DEPTH.

Reset
REQ-025 With i_rst_n low at a rising i_clk: FSM IDLE, bit count 0, timeout 0, pointers 0, o_count 0, o_valid 0, o_data 8'h00, o_frame_err 0, o_overflow 0, synchronisers all 1 (idle line).
REQ-026 Reset mid-frame SHALL abandon the frame with no error pulse; first frame after release is received normally.

Configuration
REQ-027 Macro PS2_RX_PARITY_CHECK_EN defined: STOP accepts only if the 8 data bits plus parity hold an odd number of ones; mismatch -> o_frame_err.
REQ-028 Macro PS2_RX_PARITY_CHECK_EN undefined: parity bit sampled and ignored; only stop bit and timeout produce o_frame_err.

Verification
REQ-029 Send frame 8'h1C, correct parity 0, stop 1, i_ready=1 -> o_valid pulse with o_data=8'h1C, o_count back to 0, no error.
REQ-030 Send 8'hF0 then 8'h1C with i_ready=0 -> o_count=2, o_data=8'hF0; assert i_ready two cycles -> 8'hF0 then 8'h1C, o_count 0.
REQ-031 FIFO_DEPTH=8, i_ready=0, send 9 frames 8'h01..8'h09 -> o_count=8, one o_overflow pulse at 9th push, drained bytes 8'h01..8'h08.
REQ-032 Frame 8'h1C with parity 1 -> with macro: o_frame_err pulse, o_count 0; without macro: byte 8'h1C stored.
REQ-033 Stop PS/2 clock after 4 data bits for TIMEOUT_CYCLES cycles -> one o_frame_err pulse, then valid frame 8'h5A received correctly.
REQ-034 Assert i_rst_n low after 5 data bits of a frame -> all outputs at reset values, no error pulse; next frame 8'h29 received.
